// File: rtl/uart_cmd_parser_if.sv
// Byte-stream input and decoded-command output bundle for uart_cmd_parser.
// The slave modport is the parser. The master modport is the side that feeds bytes and consumes commands.
interface uart_cmd_parser_if;
    logic [7:0] rx_data;
    logic       new_rx_data;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic [7:0] cmd_arg;
    logic       cmd_has_arg;
    logic       cmd_error;
    logic [1:0] err_code;
    logic       busy;

    modport master (
        output rx_data, new_rx_data,
        input  cmd_valid, cmd_code, cmd_arg, cmd_has_arg, cmd_error, err_code, busy
    );

    modport slave (
        input  rx_data, new_rx_data,
        output cmd_valid, cmd_code, cmd_arg, cmd_has_arg, cmd_error, err_code, busy
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// Decodes single-line ASCII commands "<letter>[<hex><hex>]<CR|LF>" from a UART byte stream.
// Emits a one-cycle valid or error pulse per command and holds the last decoded values.
module uart_cmd_parser #(
    parameter int TIMEOUT_CYCLES = 5000000,
    parameter int CNT_WIDTH      = 23
) (
    input  logic              clk,
    input  logic              rst,
    uart_cmd_parser_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, GOT_CMD, GOT_HI, GOT_LO, DISCARD} state_t;

    localparam logic [1:0] ERR_BAD_CHAR  = 2'd1;
    localparam logic [1:0] ERR_SHORT_ARG = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd3;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [7:0]           code_sh;
    logic [3:0]           hi_sh;
    logic [3:0]           lo_sh;

    function automatic logic is_term(input logic [7:0] b);
        return (b == 8'h0A) || (b == 8'h0D);
    endfunction

    function automatic logic is_letter(input logic [7:0] b);
        return ((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h61) && (b <= 8'h7A));
    endfunction

    function automatic logic is_hex(input logic [7:0] b);
        return ((b >= 8'h30) && (b <= 8'h39)) ||
               ((b >= 8'h41) && (b <= 8'h46)) ||
               ((b >= 8'h61) && (b <= 8'h66));
    endfunction

    // Letters A-F and a-f both have a low nibble of 1-6, so a single +9 maps either case.
    function automatic logic [3:0] hex_val(input logic [7:0] b);
        return (b <= 8'h39) ? b[3:0] : b[3:0] + 4'd9;
    endfunction

    assign bus.busy = (state != IDLE);

    // NOTE: all state and registered outputs use non-blocking assignments, so every
    // branch below reads the pre-edge values of state, cnt and the shadow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            code_sh         <= '0;
            hi_sh           <= '0;
            lo_sh           <= '0;
            bus.cmd_valid   <= 1'b0;
            bus.cmd_code    <= '0;
            bus.cmd_arg     <= '0;
            bus.cmd_has_arg <= 1'b0;
            bus.cmd_error   <= 1'b0;
            bus.err_code    <= '0;
        end else begin
            bus.cmd_valid <= 1'b0;
            bus.cmd_error <= 1'b0;

            if (bus.new_rx_data) begin
                // An arriving byte always takes priority over a timeout expiring in the same cycle.
                cnt <= '0;
                unique case (state)
                    IDLE: begin
                        if (is_letter(bus.rx_data)) begin
                            code_sh <= bus.rx_data;
                            state   <= GOT_CMD;
                        end else if (!is_term(bus.rx_data)) begin
                            bus.cmd_error <= 1'b1;
                            bus.err_code  <= ERR_BAD_CHAR;
                            state         <= DISCARD;
                        end
                    end
                    GOT_CMD: begin
                        if (is_term(bus.rx_data)) begin
                            bus.cmd_valid   <= 1'b1;
                            bus.cmd_code    <= code_sh;
                            bus.cmd_arg     <= 8'h00;
                            bus.cmd_has_arg <= 1'b0;
                            state           <= IDLE;
                        end else if (is_hex(bus.rx_data)) begin
                            hi_sh <= hex_val(bus.rx_data);
                            state <= GOT_HI;
                        end else begin
                            bus.cmd_error <= 1'b1;
                            bus.err_code  <= ERR_BAD_CHAR;
                            state         <= DISCARD;
                        end
                    end
                    GOT_HI: begin
                        if (is_hex(bus.rx_data)) begin
                            lo_sh <= hex_val(bus.rx_data);
                            state <= GOT_LO;
                        end else if (is_term(bus.rx_data)) begin
                            bus.cmd_error <= 1'b1;
                            bus.err_code  <= ERR_SHORT_ARG;
                            state         <= IDLE;
                        end else begin
                            bus.cmd_error <= 1'b1;
                            bus.err_code  <= ERR_BAD_CHAR;
                            state         <= DISCARD;
                        end
                    end
                    GOT_LO: begin
                        if (is_term(bus.rx_data)) begin
                            bus.cmd_valid   <= 1'b1;
                            bus.cmd_code    <= code_sh;
                            bus.cmd_arg     <= {hi_sh, lo_sh};
                            bus.cmd_has_arg <= 1'b1;
                            state           <= IDLE;
                        end else begin
                            bus.cmd_error <= 1'b1;
                            bus.err_code  <= ERR_BAD_CHAR;
                            state         <= DISCARD;
                        end
                    end
                    DISCARD: begin
                        if (is_term(bus.rx_data)) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state == IDLE) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                state <= IDLE;
                if (state != DISCARD) begin
                    bus.cmd_error <= 1'b1;
                    bus.err_code  <= ERR_TIMEOUT;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: expected pulses are queued as bytes are sent and
// compared when the parser emits cmd_valid or cmd_error.
module tb_uart_cmd_parser;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int CNT_WIDTH      = 5;

    typedef struct {
        logic       is_err;
        logic [7:0] code;
        logic [7:0] arg;
        logic       has_arg;
        logic [1:0] ecode;
    } exp_t;

    logic clk;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t sb[$];

    uart_cmd_parser_if bus ();

    uart_cmd_parser #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data     = b;
        bus.new_rx_data = 1'b1;
        @(negedge clk);
        bus.new_rx_data = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic expect_valid(input logic [7:0] code, input logic [7:0] arg, input logic has_arg);
        exp_t e;
        e = '{is_err: 1'b0, code: code, arg: arg, has_arg: has_arg, ecode: 2'd0};
        sb.push_back(e);
    endtask

    task automatic expect_error(input logic [1:0] ecode);
        exp_t e;
        e = '{is_err: 1'b1, code: 8'h00, arg: 8'h00, has_arg: 1'b0, ecode: ecode};
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},   32'(bus.cmd_valid),   32'd0);
        check({tag, "_error"},   32'(bus.cmd_error),   32'd0);
        check({tag, "_code"},    32'(bus.cmd_code),    32'd0);
        check({tag, "_arg"},     32'(bus.cmd_arg),     32'd0);
        check({tag, "_has_arg"}, 32'(bus.cmd_has_arg), 32'd0);
        check({tag, "_err_code"},32'(bus.err_code),    32'd0);
        check({tag, "_busy"},    32'(bus.busy),        32'd0);
    endtask

    // Every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (bus.cmd_valid || bus.cmd_error)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {30'd0, bus.cmd_valid, bus.cmd_error}, 32'd0);
            end else begin
                e = sb.pop_front();
                if (e.is_err) begin
                    check("err_pulse",    32'(bus.cmd_error), 32'd1);
                    check("err_no_valid", 32'(bus.cmd_valid), 32'd0);
                    check("err_code",     32'(bus.err_code),  32'(e.ecode));
                end else begin
                    check("valid_pulse",    32'(bus.cmd_valid),   32'd1);
                    check("valid_no_error", 32'(bus.cmd_error),   32'd0);
                    check("cmd_code",       32'(bus.cmd_code),    32'(e.code));
                    check("cmd_arg",        32'(bus.cmd_arg),     32'(e.arg));
                    check("cmd_has_arg",    32'(bus.cmd_has_arg), 32'(e.has_arg));
                end
            end
        end
    end

    initial begin
        rst             = 1'b1;
        bus.rx_data     = 8'h00;
        bus.new_rx_data = 1'b0;
        idle(3);
        check_all_zero("reset");
        rst = 1'b0;
        idle(2);

        // Command without argument, busy between the bytes
        send("H");
        check("busy_mid_cmd", 32'(bus.busy), 32'd1);
        expect_valid(8'h48, 8'h00, 1'b0);
        send(8'h0A);
        check("busy_after_cmd", 32'(bus.busy), 32'd0);

        // Argument command, then a bare command clears the argument fields
        send_str("w3f");
        expect_valid(8'h77, 8'h3F, 1'b1);
        send(8'h0D);
        send("W");
        expect_valid(8'h57, 8'h00, 1'b0);
        send(8'h0A);

        // Empty line in IDLE is silently ignored
        send(8'h0D);
        check("empty_line_busy", 32'(bus.busy), 32'd0);

        // Short argument leaves held command untouched
        send_str("x5");
        expect_error(2'd2);
        send(8'h0A);
        check("held_code_after_err", 32'(bus.cmd_code),    32'h57);
        check("held_has_after_err",  32'(bus.cmd_has_arg), 32'd0);
        check("busy_after_short",    32'(bus.busy),        32'd0);

        // Bad first character: single error, rest of line swallowed
        expect_error(2'd1);
        send("1");
        check("busy_discard", 32'(bus.busy), 32'd1);
        send_str("ab");
        send(8'h0A);
        check("busy_after_discard", 32'(bus.busy), 32'd0);
        send("h");
        expect_valid(8'h68, 8'h00, 1'b0);
        send(8'h0A);

        // Third hex digit is a bad character; mixed-case hex accepted
        send_str("AbC");
        expect_error(2'd1);
        send("3");
        send(8'h0A);
        send("Z");
        send_str("eD");
        expect_valid(8'h5A, 8'hED, 1'b1);
        send(8'h0D);

        // Timeout after a letter
        send("h");
        expect_error(2'd3);
        idle(TIMEOUT_CYCLES);
        check("busy_after_timeout", 32'(bus.busy), 32'd0);
        check("held_code_after_timeout", 32'(bus.cmd_code), 32'h5A);

        // A byte landing on the expiry cycle is processed instead of timing out
        send("h");
        idle(TIMEOUT_CYCLES - 2);
        send("5");
        check("busy_byte_on_expiry", 32'(bus.busy), 32'd1);
        send("A");
        expect_valid(8'h68, 8'h5A, 1'b1);
        send(8'h0D);

        // Timeout in DISCARD is silent
        expect_error(2'd1);
        send("!");
        idle(TIMEOUT_CYCLES + 4);
        check("busy_discard_timeout", 32'(bus.busy), 32'd0);

        // Reset mid-command drops it and clears held outputs
        send_str("h1");
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        check_all_zero("mid_reset");
        rst = 1'b0;
        idle(1);
        send_str("a00");
        expect_valid(8'h61, 8'h00, 1'b1);
        send(8'h0A);

        idle(4);
        check("missing_pulses", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
